// File: rtl/dispatch_credit_ctrl.sv
// rtl/dispatch_credit_ctrl.sv - credit counters, registered dispatch stall, flush recovery and protocol checking
// Optional stall-cycle counter enabled by defining DISPATCH_CREDIT_STAT_EN.
module dispatch_credit_ctrl #(
    parameter int ALU_DEPTH = 8,
    parameter int MDU_DEPTH = 4,
    parameter int LSU_DEPTH = 8,
    parameter int ROB_DEPTH = 128
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_flush,
    input  logic [1:0]                     i_alu_alloc,
    input  logic                           i_mdu_alloc,
    input  logic [1:0]                     i_lsu_alloc,
    input  logic                           i_rob_alloc,
    input  logic [1:0]                     i_alu_free,
    input  logic                           i_mdu_free,
    input  logic [1:0]                     i_lsu_free,
    input  logic                           i_rob_free,
    output logic [$clog2(ALU_DEPTH+1)-1:0] o_alu_credit,
    output logic [$clog2(MDU_DEPTH+1)-1:0] o_mdu_credit,
    output logic [$clog2(LSU_DEPTH+1)-1:0] o_lsu_credit,
    output logic [$clog2(ROB_DEPTH+1)-1:0] o_rob_credit,
    output logic                           o_dispatch_stall,
    output logic [3:0]                     o_stall_reason,
    output logic                           o_proto_err,
    output logic [31:0]                    o_stall_cycles
);
    localparam int AW = $clog2(ALU_DEPTH+1);
    localparam int MW = $clog2(MDU_DEPTH+1);
    localparam int LW = $clog2(LSU_DEPTH+1);
    localparam int RW = $clog2(ROB_DEPTH+1);

    typedef enum logic {RUN = 1'b0, FLUSH_HOLD = 1'b1} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_alu_credit, w_alu_next;
    logic [MW-1:0] r_mdu_credit, w_mdu_next;
    logic [LW-1:0] r_lsu_credit, w_lsu_next;
    logic [RW-1:0] r_rob_credit, w_rob_next;
    logic          r_stall;
    logic [3:0]    r_reason;
    logic          r_proto_err;
    logic [3:0]    w_thr;
    logic [3:0]    w_err;
    logic          w_hold;
    logic          w_alloc_any;
    logic [1:0]    w_alu_eff, w_alu_frees, w_lsu_eff, w_lsu_frees;
    logic          w_mdu_eff, w_mdu_frees, w_rob_eff, w_rob_frees;

    // Out-of-range results are protocol errors; the counter is pinned to the legal range.
    function automatic int clamp_credit(input int sum, input int depth, output logic err);
        err = 1'b0;
        clamp_credit = sum;
        if (sum > depth) begin
            err = 1'b1;
            clamp_credit = depth;
        end else if (sum < 0) begin
            err = 1'b1;
            clamp_credit = 0;
        end
    endfunction

    always_comb begin
        w_hold      = (r_state == FLUSH_HOLD);
        w_alu_eff   = r_stall ? 2'b00 : i_alu_alloc;
        w_mdu_eff   = r_stall ? 1'b0  : i_mdu_alloc;
        w_lsu_eff   = r_stall ? 2'b00 : i_lsu_alloc;
        w_rob_eff   = r_stall ? 1'b0  : i_rob_alloc;
        w_alu_frees = w_hold ? 2'b00 : i_alu_free;
        w_mdu_frees = w_hold ? 1'b0  : i_mdu_free;
        w_lsu_frees = w_hold ? 2'b00 : i_lsu_free;
        w_rob_frees = w_hold ? 1'b0  : i_rob_free;
        w_err       = 4'b0000;

        w_alu_next = AW'(clamp_credit(int'(r_alu_credit) - int'(w_alu_eff) + int'(w_alu_frees),
                                      ALU_DEPTH, w_err[0]));
        w_mdu_next = MW'(clamp_credit(int'(r_mdu_credit) - int'(w_mdu_eff) + int'(w_mdu_frees),
                                      MDU_DEPTH, w_err[1]));
        w_lsu_next = LW'(clamp_credit(int'(r_lsu_credit) - int'(w_lsu_eff) + int'(w_lsu_frees),
                                      LSU_DEPTH, w_err[2]));
        w_rob_next = RW'(clamp_credit(int'(r_rob_credit) - int'(w_rob_eff) + int'(w_rob_frees),
                                      ROB_DEPTH, w_err[3]));

        // Flush overrides every allocate and free in the same cycle.
        if (i_flush) begin
            w_alu_next = AW'(ALU_DEPTH);
            w_mdu_next = MW'(MDU_DEPTH);
            w_lsu_next = LW'(LSU_DEPTH);
            w_rob_next = RW'(ROB_DEPTH);
            w_err      = 4'b0000;
        end

        w_thr[0]     = (w_alu_next < AW'(2));
        w_thr[1]     = (w_mdu_next == '0);
        w_thr[2]     = (w_lsu_next < LW'(2));
        w_thr[3]     = (w_rob_next == '0);
        w_state_next = i_flush ? FLUSH_HOLD : RUN;
        w_alloc_any  = (|i_alu_alloc) | i_mdu_alloc | (|i_lsu_alloc) | i_rob_alloc;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= RUN;
            r_alu_credit <= AW'(ALU_DEPTH);
            r_mdu_credit <= MW'(MDU_DEPTH);
            r_lsu_credit <= LW'(LSU_DEPTH);
            r_rob_credit <= RW'(ROB_DEPTH);
            r_stall      <= 1'b0;
            r_reason     <= 4'b0000;
            r_proto_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_alu_credit <= w_alu_next;
            r_mdu_credit <= w_mdu_next;
            r_lsu_credit <= w_lsu_next;
            r_rob_credit <= w_rob_next;
            r_stall      <= (|w_thr) | (w_state_next == FLUSH_HOLD);
            r_reason     <= w_thr;
            r_proto_err  <= r_proto_err | (r_stall & w_alloc_any) | (|w_err);
        end
    end

`ifdef DISPATCH_CREDIT_STAT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cycles <= 32'd0;
        end else if (r_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`else
    assign o_stall_cycles = 32'd0;
`endif

    assign o_alu_credit     = r_alu_credit;
    assign o_mdu_credit     = r_mdu_credit;
    assign o_lsu_credit     = r_lsu_credit;
    assign o_rob_credit     = r_rob_credit;
    assign o_dispatch_stall = r_stall;
    assign o_stall_reason   = r_reason;
    assign o_proto_err      = r_proto_err;
endmodule
